even_parity_serial_tx: RTL and testbench
========================================

Name: even_parity_serial_tx

Overview:
- Downstream consumer of the 4-bit even parity generator.
- Accepts one data word plus its generated parity bit over a valid/ready handshake.
- Serializes the word as a framed bit stream on one line: start bit, data LSB-first, parity bit, stop bit.
- Feeds the board-level serial link. The matching receiver/checker is a separate block.

Parameters:
- DATA_W, 4, data word width in bits (≥1).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx_out (≥1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  DATA_W  word to transmit, sampled only at handshake.
- parity_in  input  1  even parity bit from upstream generator, sampled at handshake.
- in_valid  input  1  upstream has a word.
- in_ready  output  1  block can accept a word this cycle.
- tx_out  output  1  serial line; idle level 1.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (async, rst_n=0): tx_out=1, busy=0, frame_done=0, in_ready=1 after release. All counters are cleared and state=IDLE.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered except in_ready, which equals (state==IDLE).
- IDLE:
  - tx_out=1, busy=0.
  - Accept when in_valid && in_ready on a rising edge: latch data_in into the shift register and parity_in into the parity register, then go to START.
- START: tx_out=0 for CLKS_PER_BIT cycles.
- DATA:
  - tx_out=shift_reg[0] for CLKS_PER_BIT cycles per bit, then shift right.
  - Bit counter runs 0..DATA_W-1. After bit DATA_W-1, go to PARITY.
- PARITY: tx_out=latched parity for CLKS_PER_BIT cycles.
- STOP:
  - tx_out=1 for CLKS_PER_BIT cycles.
  - frame_done=1 in the final cycle of STOP, then go to IDLE.
- Timing:
  - tx_out shows the start bit in the first cycle after the accept edge.
  - Frame length is (DATA_W+3)*CLKS_PER_BIT cycles.
  - busy=1 for exactly those cycles.
- Back-to-back: in_ready rises in the cycle after frame_done. A word held valid is accepted then, and its start bit follows with no idle bit between frames.
- Input changes on data_in/parity_in/in_valid while busy are ignored. No word is lost because in_ready=0.
- CLKS_PER_BIT=1: each bit lasts one cycle. frame_done coincides with the single stop cycle.
- Reset mid-frame: tx_out returns to 1 immediately (asynchronously) and the partial frame is discarded. No frame_done is issued.
- parity_in is transmitted as given. The block does not correct it.

Optional Feature:
- Macro: PARITY_SELF_CHECK_EN.
- Defined:
  - Adds output port parity_err (1 bit, reset 0).
  - At each accept, registers parity_err = (^data_in) ^ parity_in, i.e. 1 when the upstream parity is not even.
  - Holds the value until the next accept. The frame is still sent with parity_in unchanged.
- Undefined: the port and all of its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package even_parity_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP).
  - IDLE_LEVEL=1'b1 and START_LEVEL=1'b0 constants.
  - frame_len(DATA_W, CLKS_PER_BIT) function.
- Sub-module bit_timer:
  - Counts 0..CLKS_PER_BIT-1 and emits bit_end on the terminal count.
  - Cleared by restart (asserted at accept) and by rst_n.

Test Plan (DATA_W=4, CLKS_PER_BIT=4):
- Reset → tx_out=1, busy=0, frame_done=0, in_ready=1. Assert rst_n=0 mid-cycle → outputs change without waiting for a clock edge.
- data_in=4'b0011, parity_in=0, one-cycle valid → tx_out bits 0,1,1,0,0,0,1, each held 4 cycles. busy high 28 cycles. frame_done single pulse on cycle 28 after accept.
- data_in=4'b0111, parity_in=1 → parity-bit window (cycles 21–24) shows tx_out=1. Total length is 28 cycles.
- in_valid held high with 4'b1010 during the frame, then 4'b0101 → 4'b1010 accepted only in the cycle after frame_done. Its start bit immediately follows the previous stop bit, and 4'b0101 is never accepted mid-frame.
- rst_n pulsed low during the third data bit → tx_out=1 and busy=0 at once. No frame_done. Next accept produces a clean full frame.
- PARITY_SELF_CHECK_EN defined:
  - 4'b0001 with parity_in=0 → parity_err=1 after accept, and the frame still carries parity 0.
  - Next 4'b0001 with parity_in=1 → parity_err=0.

Source files
------------

// File: rtl/even_parity_pkg.sv
// even_parity_pkg: shared states, line levels and frame-length helper for the serial transmitter
package even_parity_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  function automatic int frame_len(input int data_w, input int clks_per_bit);
    return (data_w + 3) * clks_per_bit;
  endfunction
endpackage

// File: rtl/even_parity_serial_tx_bit_timer.sv
// bit_timer: counts clocks within one serial bit
// Ports: clk, rst_n (async low); run counts while high; restart clears the count;
// bit_end flags the terminal count; pre_end flags that the next cycle holds the terminal count.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic bit_end,
  output logic pre_end
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] cnt;
  assign bit_end = run && cnt == CW'(CLKS_PER_BIT - 1);
  // after a clear the next count is 0, which is terminal only for one-cycle bits
  assign pre_end = (CLKS_PER_BIT == 1) || (!restart && !bit_end && cnt == CW'(CLKS_PER_BIT - 2));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (restart || bit_end) cnt <= '0;
    else if (run) cnt <= cnt + 1'b1;
endmodule

// File: rtl/even_parity_serial_tx.sv
// even_parity_serial_tx: frames a data word plus parity as start, data LSB-first, parity, stop
// Ports: clk, rst_n (async low); data_in/parity_in/in_valid/in_ready handshake;
// tx_out serial line (idle 1); busy while a frame is on the line; frame_done on the last stop cycle.
// Optional macro PARITY_SELF_CHECK_EN adds parity_err, the registered odd-parity flag of the last accepted word.
module even_parity_serial_tx
  import even_parity_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
`ifdef PARITY_SELF_CHECK_EN
  ,
  output logic              parity_err
`endif
);
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  state_t state, state_nx;
  logic [DATA_W-1:0] shift, shift_nx, shift_dn;
  logic [IW-1:0] idx, idx_nx;
  logic par, par_nx, tx_nx, accept, bit_end, pre_end;
  assign in_ready = state == IDLE;
  assign accept = in_valid && in_ready;
  assign shift_dn = shift >> 1;
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .run(state != IDLE),
    .restart(accept),
    .bit_end(bit_end),
    .pre_end(pre_end)
  );
  always_comb begin
    state_nx = state;
    shift_nx = shift;
    idx_nx = idx;
    par_nx = par;
    tx_nx = tx_out;
    unique case (state)
      IDLE: begin
        tx_nx = accept ? START_LEVEL : IDLE_LEVEL;
        if (accept) begin
          state_nx = START;
          shift_nx = data_in;
          par_nx = parity_in;
          idx_nx = '0;
        end
      end
      START: if (bit_end) begin
        state_nx = DATA;
        tx_nx = shift[0];
      end
      DATA: if (bit_end) begin
        if (idx == IW'(DATA_W - 1)) begin
          state_nx = PARITY;
          tx_nx = par;
        end else begin
          shift_nx = shift_dn;
          idx_nx = idx + 1'b1;
          tx_nx = shift_dn[0];
        end
      end
      PARITY: if (bit_end) begin
        state_nx = STOP;
        tx_nx = IDLE_LEVEL;
      end
      STOP: if (bit_end) begin
        state_nx = IDLE;
        tx_nx = IDLE_LEVEL;
      end
      default: begin
        state_nx = IDLE;
        tx_nx = IDLE_LEVEL;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      shift <= '0;
      idx <= '0;
      par <= 1'b0;
      tx_out <= IDLE_LEVEL;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_nx;
      shift <= shift_nx;
      idx <= idx_nx;
      par <= par_nx;
      tx_out <= tx_nx;
      busy <= state_nx != IDLE;
      // registered, so flag the cycle that will be the final stop cycle
      frame_done <= state_nx == STOP && pre_end;
    end
`ifdef PARITY_SELF_CHECK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) parity_err <= 1'b0;
    else if (accept) parity_err <= (^data_in) ^ parity_in;
`endif
endmodule

// File: tb/tb_even_parity_serial_tx.sv
// tb_even_parity_serial_tx: table vectors, corner sequences and random frames against a frame model
module tb_even_parity_serial_tx;
  import even_parity_pkg::*;
  localparam int DW = 4;
  localparam int CPB = 4;
  localparam int FL = frame_len(DW, CPB);
  logic clk = 0, rst_n = 0, parity_in = 0, in_valid = 0;
  logic [DW-1:0] data_in = '0;
  logic in_ready, tx_out, busy, frame_done;
  int checks = 0, failures = 0;
`ifdef PARITY_SELF_CHECK_EN
  logic parity_err;
`endif
  even_parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .parity_in(parity_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx_out(tx_out),
    .busy(busy),
    .frame_done(frame_done)
`ifdef PARITY_SELF_CHECK_EN
    ,
    .parity_err(parity_err)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [DW-1:0] d;
    logic p;
    logic [DW+2:0] bits;
    logic err;
  } vec_t;
  vec_t tbl[4];
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask
  // Sends one word and checks the whole frame cycle by cycle; nd/np are driven right after accept.
  task automatic frame(input logic [DW-1:0] d, input logic p, input logic [DW+2:0] bits,
                       input logic hold, input logic [DW-1:0] nd, input logic np,
                       input logic expect_now, input string nm);
    int w = 0;
    logic [FL-1:0] txw, bw, dw, rw, etx;
    @(negedge clk);
    data_in = d;
    parity_in = p;
    in_valid = 1;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      $display("FAIL %s accept_timeout got=0 expected=1", nm);
      failures++;
      checks++;
      in_valid = 0;
      return;
    end
    if (expect_now) chk({nm, "_back_to_back_wait"}, 64'(w), 64'd0);
    @(posedge clk);
    #1;
    in_valid = hold;
    data_in = nd;
    parity_in = np;
    for (int k = 0; k < FL; k++) begin
      txw[k] = tx_out;
      bw[k] = busy;
      dw[k] = frame_done;
      rw[k] = in_ready;
      etx[k] = bits[k / CPB];
      @(posedge clk);
      #1;
    end
    chk({nm, "_tx"}, 64'(txw), 64'(etx));
    chk({nm, "_busy"}, 64'(bw), 64'({FL{1'b1}}));
    chk({nm, "_done"}, 64'(dw), 64'(1) << (FL - 1));
    chk({nm, "_ready_low"}, 64'(rw), 64'd0);
    chk({nm, "_after_idle"}, {61'd0, tx_out, busy, in_ready}, 64'b101);
  endtask
  initial begin
    tbl[0] = '{4'b0011, 1'b0, 7'b1000110, 1'b0};
    tbl[1] = '{4'b0111, 1'b1, 7'b1101110, 1'b0};
    tbl[2] = '{4'b0001, 1'b0, 7'b1000010, 1'b1};
    tbl[3] = '{4'b0001, 1'b1, 7'b1100010, 1'b0};
    #12;
    chk("reset_state", {60'd0, tx_out, busy, frame_done, in_ready}, 64'b1001);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_reset_idle", {60'd0, tx_out, busy, frame_done, in_ready}, 64'b1001);
`ifdef PARITY_SELF_CHECK_EN
    chk("parity_err_reset", 64'(parity_err), 64'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      frame(tbl[i].d, tbl[i].p, tbl[i].bits, 1'b0, tbl[i].d, tbl[i].p, 1'b0, $sformatf("vec%0d", i));
`ifdef PARITY_SELF_CHECK_EN
      chk($sformatf("vec%0d_parity_err", i), 64'(parity_err), 64'(tbl[i].err));
`endif
    end
    frame(4'b0011, 1'b0, 7'b1000110, 1'b1, 4'b1010, 1'b0, 1'b0, "b2b_a");
    frame(4'b1010, 1'b0, 7'b1010100, 1'b1, 4'b0101, 1'b0, 1'b1, "b2b_b");
    frame(4'b0101, 1'b0, 7'b1001010, 1'b0, 4'b0000, 1'b0, 1'b1, "b2b_c");
    @(negedge clk);
    data_in = 4'b0011;
    parity_in = 0;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (13) @(posedge clk);
    #1;
    chk("third_bit_low", 64'(tx_out), 64'd0);
    #2;
    rst_n = 0;
    #1;
    chk("async_reset_midframe", {60'd0, tx_out, busy, frame_done, in_ready}, 64'b1001);
    @(negedge clk);
    rst_n = 1;
    begin
      logic seen = 0;
      for (int k = 0; k < 2 * FL; k++) begin
        @(posedge clk);
        #1;
        seen |= frame_done | busy;
      end
      chk("no_done_after_abort", 64'(seen), 64'd0);
    end
    frame(4'b0011, 1'b0, 7'b1000110, 1'b0, 4'b0, 1'b0, 1'b0, "clean_after_reset");
    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] d = DW'($urandom);
      logic p = 1'($urandom);
      frame(d, p, {1'b1, p, d, 1'b0}, 1'b0, DW'($urandom), 1'($urandom), 1'b0, $sformatf("rnd%0d", i));
`ifdef PARITY_SELF_CHECK_EN
      chk($sformatf("rnd%0d_parity_err", i), 64'(parity_err), 64'((^d) ^ p));
`else
      chk($sformatf("rnd%0d_idle_level", i), 64'(tx_out), 64'(IDLE_LEVEL));
`endif
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
